// File: rtl/mips_hazard_ctrl.sv
// Hazard/pipeline control for the 5-stage MIPS core: load-use stalls, branch flushes,
// EX operand forwarding selects and HALT drain sequencing.
module mips_hazard_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             ex_valid,
    input  logic [5:0]       ex_op,
    input  logic [4:0]       ex_dst,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             br_taken,
    input  logic             mem_we,
    input  logic [4:0]       mem_dst,
    input  logic             wb_we,
    input  logic [4:0]       wb_dst,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_MUL  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_AND  = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h06;
    localparam logic [5:0] OP_SUBI = 6'h07;
    localparam logic [5:0] OP_MULI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h09;
    localparam logic [5:0] OP_ANDI = 6'h0A;
    localparam logic [5:0] OP_XORI = 6'h0B;
    localparam logic [5:0] OP_LDW  = 6'h0C;
    localparam logic [5:0] OP_STW  = 6'h0D;
    localparam logic [5:0] OP_BZ   = 6'h0E;
    localparam logic [5:0] OP_BEQ  = 6'h0F;
    localparam logic [5:0] OP_JR   = 6'h10;
    localparam logic [5:0] OP_HALT = 6'h11;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [DRN_W-1:0] drain_cnt, drain_n;
    logic             stall_inc, flush_inc;

    logic [5:0] id_op;
    logic [4:0] id_rs, id_rt;
    logic       rd_rs, rd_rt;
    logic       load_use, halt_id;
    logic       unused_imm;

    assign id_op      = id_instr[31:26];
    assign id_rs      = id_instr[25:21];
    assign id_rt      = id_instr[20:16];
    assign unused_imm = ^id_instr[15:0];

    // Which source fields the ID instruction actually reads
    always_comb begin
        rd_rs = 1'b0;
        rd_rt = 1'b0;
        case (id_op)
            OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR, OP_STW, OP_BEQ: begin
                rd_rs = 1'b1;
                rd_rt = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI, OP_LDW, OP_BZ, OP_JR: begin
                rd_rs = 1'b1;
            end
            default: ;
        endcase
    end

    assign load_use = ex_valid && (ex_op == OP_LDW) && id_valid && (ex_dst != 5'd0) &&
                      ((rd_rs && (ex_dst == id_rs)) || (rd_rt && (ex_dst == id_rt)));
    assign halt_id  = id_valid && (id_op == OP_HALT);

    // Operand forwarding; MEM result is newer than WB so it wins
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_we && (mem_dst != 5'd0) && (mem_dst == ex_rs))
            fwd_a = FWD_MEM;
        else if (wb_we && (wb_dst != 5'd0) && (wb_dst == ex_rs))
            fwd_a = FWD_WB;
        if (mem_we && (mem_dst != 5'd0) && (mem_dst == ex_rt))
            fwd_b = FWD_MEM;
        else if (wb_we && (wb_dst != 5'd0) && (wb_dst == ex_rt))
            fwd_b = FWD_WB;
        if (rst) begin
            fwd_a = FWD_RF;
            fwd_b = FWD_RF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_n;
        end
    end

    // Next state and pipeline enables
    always_comb begin
        state_n      = state;
        drain_n      = drain_cnt;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        case (state)
            S_RUN: begin
                if (br_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    flush_inc    = 1'b1;
                end else if (halt_id) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_n      = S_DRAIN;
                    drain_n      = DRN_W'(DRAIN_CYC - 1);
                end else if (load_use) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                    stall_inc    = 1'b1;
                end
            end
            S_DRAIN: begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
                if (drain_cnt == '0)
                    state_n = S_HALTED;
                else
                    drain_n = drain_cnt - DRN_W'(1);
            end
            S_HALTED: begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: state_n = S_RUN;
        endcase
        if (rst) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b0;
            flush_inc    = 1'b0;
        end
    end

    // Sticky halt flag and saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            halted <= (state_n == S_HALTED);
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Scoreboard bench for mips_hazard_ctrl: each driven cycle pushes its expected outputs,
// a negedge monitor pops and compares them.
module tb_mips_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_valid;
    logic [5:0]  ex_op;
    logic [4:0]  ex_dst, ex_rs, ex_rt;
    logic        br_taken;
    logic        mem_we;
    logic [4:0]  mem_dst;
    logic        wb_we;
    logic [4:0]  wb_dst;
    logic        pc_we, if_id_we, if_id_flush, id_ex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic        halted;
    logic [15:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic        rst;
        logic        id_valid;
        logic [31:0] id_instr;
        logic        ex_valid;
        logic [5:0]  ex_op;
        logic [4:0]  ex_dst;
        logic [4:0]  ex_rs;
        logic [4:0]  ex_rt;
        logic        br_taken;
        logic        mem_we;
        logic [4:0]  mem_dst;
        logic        wb_we;
        logic [4:0]  wb_dst;
    } stim_t;

    typedef struct packed {
        logic [15:0] vec;
        logic        pc_we;
        logic        if_id_we;
        logic        if_id_flush;
        logic        id_ex_bubble;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic        halted;
        logic [15:0] stall_cnt;
        logic [15:0] flush_cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          vec_no   = 0;
    logic        m_halted = 1'b0;
    logic [15:0] m_stall  = 16'd0;
    logic [15:0] m_flush  = 16'd0;

    mips_hazard_ctrl #(.CNT_W(16), .DRAIN_CYC(3)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_dst(ex_dst), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .br_taken(br_taken), .mem_we(mem_we), .mem_dst(mem_dst), .wb_we(wb_we), .wb_dst(wb_dst),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic exp_t mk_exp(input logic pw, input logic iw, input logic fl, input logic bb);
        exp_t e;
        e = '0;
        e.vec          = 16'(vec_no);
        e.pc_we        = pw;
        e.if_id_we     = iw;
        e.if_id_flush  = fl;
        e.id_ex_bubble = bb;
        e.halted       = m_halted;
        e.stall_cnt    = m_stall;
        e.flush_cnt    = m_flush;
        return e;
    endfunction

    function automatic exp_t e_run();   return mk_exp(1'b1, 1'b1, 1'b0, 1'b0); endfunction
    function automatic exp_t e_stall(); return mk_exp(1'b0, 1'b0, 1'b0, 1'b1); endfunction
    function automatic exp_t e_flush(); return mk_exp(1'b1, 1'b1, 1'b1, 1'b1); endfunction
    function automatic exp_t e_rst();   return mk_exp(1'b0, 1'b0, 1'b1, 1'b1); endfunction

    task automatic apply(input stim_t s, input exp_t e);
        rst      = s.rst;
        id_valid = s.id_valid;
        id_instr = s.id_instr;
        ex_valid = s.ex_valid;
        ex_op    = s.ex_op;
        ex_dst   = s.ex_dst;
        ex_rs    = s.ex_rs;
        ex_rt    = s.ex_rt;
        br_taken = s.br_taken;
        mem_we   = s.mem_we;
        mem_dst  = s.mem_dst;
        wb_we    = s.wb_we;
        wb_dst   = s.wb_dst;
        sb_q.push_back(e);
        vec_no++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk($sformatf("v%0d pc_we", e.vec), 32'(pc_we), 32'(e.pc_we));
            chk($sformatf("v%0d if_id_we", e.vec), 32'(if_id_we), 32'(e.if_id_we));
            chk($sformatf("v%0d if_id_flush", e.vec), 32'(if_id_flush), 32'(e.if_id_flush));
            chk($sformatf("v%0d id_ex_bubble", e.vec), 32'(id_ex_bubble), 32'(e.id_ex_bubble));
            chk($sformatf("v%0d fwd_a", e.vec), 32'(fwd_a), 32'(e.fwd_a));
            chk($sformatf("v%0d fwd_b", e.vec), 32'(fwd_b), 32'(e.fwd_b));
            chk($sformatf("v%0d halted", e.vec), 32'(halted), 32'(e.halted));
            chk($sformatf("v%0d stall_cnt", e.vec), 32'(stall_cnt), 32'(e.stall_cnt));
            chk($sformatf("v%0d flush_cnt", e.vec), 32'(flush_cnt), 32'(e.flush_cnt));
        end
    end

    initial begin
        stim_t s;
        exp_t  e;
        logic [31:0] halt_w;
        halt_w = 32'h4400_0000;

        s = idle();
        s.rst = 1'b1;
        rst = 1'b1; id_valid = 1'b0; id_instr = '0; ex_valid = 1'b0; ex_op = '0;
        ex_dst = '0; ex_rs = '0; ex_rt = '0; br_taken = 1'b0; mem_we = 1'b0;
        mem_dst = '0; wb_we = 1'b0; wb_dst = '0;
        @(posedge clk);
        #1;

        // Reset forces the control outputs even with a forwarding match present
        s = idle(); s.rst = 1'b1; s.ex_rs = 5'd7; s.mem_we = 1'b1; s.mem_dst = 5'd7;
        apply(s, e_rst());
        apply(idle(), e_run());

        // Load-use on rs: one stall cycle then normal flow
        s = idle(); s.ex_valid = 1'b1; s.ex_op = 6'h0C; s.ex_dst = 5'd3;
        s.id_valid = 1'b1; s.id_instr = mk(6'h00, 5'd3, 5'd5, 5'd4);
        apply(s, e_stall());
        m_stall = 16'd1;
        s.ex_valid = 1'b0;
        apply(s, e_run());

        // Load-use on rt of a two-source op
        s = idle(); s.ex_valid = 1'b1; s.ex_op = 6'h0C; s.ex_dst = 5'd5;
        s.id_valid = 1'b1; s.id_instr = mk(6'h0D, 5'd1, 5'd5, 5'd0);
        apply(s, e_stall());
        m_stall = 16'd2;
        // rs-only op: a match on its rt field is not a hazard
        s.id_instr = mk(6'h06, 5'd1, 5'd5, 5'd0);
        apply(s, e_run());
        // r0 never hazards
        s.ex_dst = 5'd0; s.id_instr = mk(6'h00, 5'd0, 5'd0, 5'd2);
        apply(s, e_run());
        // Undefined opcode reads nothing
        s.ex_dst = 5'd5; s.id_instr = mk(6'h20, 5'd5, 5'd5, 5'd0);
        apply(s, e_run());
        // Non-LDW producer does not stall
        s.ex_op = 6'h00; s.id_instr = mk(6'h00, 5'd5, 5'd5, 5'd1);
        apply(s, e_run());
        // id_valid low suppresses the hazard
        s.ex_op = 6'h0C; s.id_valid = 1'b0;
        apply(s, e_run());

        // Forwarding: MEM beats WB, then WB alone, then r0
        s = idle(); s.ex_rs = 5'd7; s.ex_rt = 5'd7; s.mem_we = 1'b1; s.mem_dst = 5'd7;
        s.wb_we = 1'b1; s.wb_dst = 5'd7;
        e = e_run(); e.fwd_a = 2'b10; e.fwd_b = 2'b10;
        apply(s, e);
        s.mem_we = 1'b0;
        e = e_run(); e.fwd_a = 2'b01; e.fwd_b = 2'b01;
        apply(s, e);
        s.ex_rt = 5'd0; s.wb_dst = 5'd0; s.ex_rs = 5'd0; s.mem_we = 1'b1; s.mem_dst = 5'd0;
        apply(s, e_run());
        s = idle(); s.ex_rs = 5'd7; s.ex_rt = 5'd9; s.mem_we = 1'b1; s.mem_dst = 5'd9;
        s.wb_we = 1'b1; s.wb_dst = 5'd7;
        e = e_run(); e.fwd_a = 2'b01; e.fwd_b = 2'b10;
        apply(s, e);

        // Branch overrides a simultaneous load-use
        s = idle(); s.br_taken = 1'b1; s.ex_valid = 1'b1; s.ex_op = 6'h0C; s.ex_dst = 5'd3;
        s.id_valid = 1'b1; s.id_instr = mk(6'h00, 5'd3, 5'd5, 5'd4);
        apply(s, e_flush());
        m_flush = 16'd1;
        // Branch overrides HALT in ID; stays in RUN
        s = idle(); s.br_taken = 1'b1; s.id_valid = 1'b1; s.id_instr = halt_w;
        apply(s, e_flush());
        m_flush = 16'd2;
        apply(idle(), e_run());
        apply(idle(), e_run());

        // HALT at t: freeze from t, drain t+1..t+3, halted at t+4
        s = idle(); s.id_valid = 1'b1; s.id_instr = halt_w;
        apply(s, e_stall());
        s = idle(); s.br_taken = 1'b1; s.ex_valid = 1'b1; s.ex_op = 6'h0C; s.ex_dst = 5'd3;
        s.id_valid = 1'b1; s.id_instr = mk(6'h00, 5'd3, 5'd5, 5'd4);
        apply(s, e_stall());
        apply(s, e_stall());
        apply(idle(), e_stall());
        m_halted = 1'b1;
        apply(idle(), e_stall());
        apply(s, e_stall());
        apply(idle(), e_stall());

        // Reset out of HALTED
        s = idle(); s.rst = 1'b1;
        apply(s, e_rst());
        m_halted = 1'b0; m_stall = 16'd0; m_flush = 16'd0;
        apply(idle(), e_run());

        // Reset in the middle of DRAIN
        s = idle(); s.id_valid = 1'b1; s.id_instr = halt_w;
        apply(s, e_stall());
        apply(idle(), e_stall());
        s = idle(); s.rst = 1'b1;
        apply(s, e_rst());
        apply(idle(), e_run());
        apply(idle(), e_run());
        apply(idle(), e_run());
        apply(idle(), e_run());

        // Let the monitor consume the last entry, bounded
        for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        if (n_checks < 12) chk("check_count", 32'(n_checks), 32'd12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_hazard_ctrl.md
Name: mips_hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS core (IF/ID/EX/MEM/WB) running the team ISA (ADD..HALT, opcodes 6'h00-6'h11).
- Decodes the ID-stage instruction's source and destination registers and compares them against EX/MEM/WB pipeline-register info.
- Drives PC and IF/ID write enables, bubble/flush controls and EX operand forwarding selects.
- Sequences HALT: stops fetch, drains the pipe, then asserts a sticky halted flag.

Parameters:
- CNT_W, 16, width of saturating stall and flush event counters.
- DRAIN_CYC, 3, cycles spent in DRAIN after HALT leaves ID (covers EX, MEM, WB).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  IF/ID register holds a valid instruction
- id_instr  in  32  IF/ID instruction word
- ex_valid  in  1  ID/EX holds a valid instruction
- ex_op  in  6  opcode in ID/EX
- ex_dst  in  5  destination register in ID/EX
- ex_rs  in  5  rs field in ID/EX (operand A)
- ex_rt  in  5  rt field in ID/EX (operand B)
- br_taken  in  1  EX resolved BZ/BEQ/JR as taken this cycle
- mem_we  in  1  EX/MEM writes a register
- mem_dst  in  5  EX/MEM destination
- wb_we  in  1  MEM/WB writes a register
- wb_dst  in  5  MEM/WB destination
- pc_we  out  1  PC update enable
- if_id_we  out  1  IF/ID load enable
- if_id_flush  out  1  clear IF/ID to bubble at next edge
- id_ex_bubble  out  1  load bubble into ID/EX at next edge
- fwd_a  out  2  EX operand A source: 00 regfile, 10 EX/MEM, 01 MEM/WB
- fwd_b  out  2  EX operand B source, same encoding
- halted  out  1  sticky; pipeline drained after HALT
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  taken-branch flush events, saturating

Behaviour:
- ID decode: opcode = id_instr[31:26], rs = [25:21], rt = [20:16].
  - Reads rs+rt: ADD, SUB, MUL, OR, AND, XOR, STW, BEQ.
  - Reads rs only: ADDI, SUBI, MULI, ORI, ANDI, XORI, LDW, BZ, JR.
  - HALT reads none. Undefined opcodes read none and raise no hazard.
- Register 0 never causes a hazard and is never forwarded.
- Load-use (RUN only): ex_valid && ex_op==LDW (6'h0C) && id_valid && ex_dst!=0 && ex_dst matches any ID-read source.
  - Outputs: pc_we=0, if_id_we=0, id_ex_bubble=1, if_id_flush=0, for exactly one cycle per hazard. stall_cnt++.
- Taken branch (RUN): br_taken=1 -> pc_we=1, if_id_we=1, if_id_flush=1, id_ex_bubble=1 (2 bubbles). flush_cnt++.
  - Branch overrides a simultaneous load-use stall and a simultaneous HALT in ID; stall_cnt is not incremented.
- Forwarding (combinational, all states):
  - fwd_a=10 if mem_we && mem_dst!=0 && mem_dst==ex_rs; else 01 if wb_we && wb_dst!=0 && wb_dst==ex_rs; else 00.
  - fwd_b is the same using ex_rt. MEM has priority over WB.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN: id_valid && opcode==HALT (6'h11) && !br_taken. In that cycle: pc_we=0, if_id_we=0, id_ex_bubble=1, so HALT is not propagated.
  - DRAIN: pc_we=0, if_id_we=0, id_ex_bubble=1. A down-counter loaded with DRAIN_CYC-1 on entry. br_taken and load-use are ignored.
  - DRAIN -> HALTED when the counter reaches 0, i.e. DRAIN lasts DRAIN_CYC cycles.
  - HALTED: same outputs as DRAIN, halted=1. Exit only by reset.
- Otherwise in RUN: pc_we=1, if_id_we=1, flush=0, bubble=0.
- Counters saturate at all-ones.
- Reset (sampled at clk edge, any state including mid-DRAIN):
  - state=RUN, drain counter=0, halted=0, stall_cnt=0, flush_cnt=0.
  - While rst=1, combinational outputs are forced to pc_we=0, if_id_we=0, if_id_flush=1, id_ex_bubble=1, fwd_a=fwd_b=00.

Test Plan:
- LDW r3 in EX (ex_dst=3), ID=ADD rd=4,rs=3,rt=5 -> one cycle pc_we=0, if_id_we=0, id_ex_bubble=1; stall_cnt 0->1; next cycle (EX no longer LDW) normal flow.
- ex_rs=7, mem_we=1 mem_dst=7, wb_we=1 wb_dst=7 -> fwd_a=10. Drop mem_we -> fwd_a=01. ex_rt=0 with wb_dst=0 wb_we=1 -> fwd_b=00.
- br_taken=1 while LDW-use hazard present in ID -> if_id_flush=1, id_ex_bubble=1, pc_we=1; stall_cnt unchanged, flush_cnt +1.
- HALT (32'h44000000) in ID with id_valid, br_taken=0 at cycle t -> pc_we=0 from t; DRAIN cycles t+1..t+3; halted=1 at t+4 and stays high.
- HALT in ID with br_taken=1 -> flush, state stays RUN, halted stays 0.
- rst=1 during DRAIN (cycle t+2) -> next cycle state RUN, halted=0, counters 0; after rst drops, pc_we=1 with no hazards present.
